// File: rtl/bullet_launcher_if.sv
// Fire-control bundle between input conditioning (master) and the bullet launcher (slave).
// The launcher's outputs feed the bullet slots. in_use comes back from those slots.
interface bullet_launcher_if #(
    parameter int NUM_BULLETS = 4
);
    logic                   fire;
    logic                   direction_in;
    logic [9:0]             shipX;
    logic [NUM_BULLETS-1:0] in_use;
    logic [NUM_BULLETS-1:0] start_bullet;
    logic                   direction;
    logic [9:0]             launch_x;
    logic                   busy;
    logic                   drop;
    logic [7:0]             shots_fired;

    modport master (
        output fire, direction_in, shipX, in_use,
        input  start_bullet, direction, launch_x, busy, drop, shots_fired
    );

    modport slave (
        input  fire, direction_in, shipX, in_use,
        output start_bullet, direction, launch_x, busy, drop, shots_fired
    );
endinterface

// File: rtl/bullet_launcher.sv
// Round-robin bullet launcher with ack timeout and per-shot frame cooldown.
// Optional macro BULLET_LAUNCHER_AUTOFIRE_EN: in IDLE, a fire level (not only a rise) starts a launch.
module bullet_launcher #(
    parameter int NUM_BULLETS = 4,
    parameter int COOLDOWN    = 8,
    parameter int ACK_TIMEOUT = 3
) (
    input  logic              clk_60hz,
    input  logic              reset,
    bullet_launcher_if.slave  bus
);

    localparam int             PTR_W     = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [7:0]     COOL_INIT = 8'(COOLDOWN);
    localparam logic [3:0]     ACK_INIT  = 4'(ACK_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_BULLETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_ACK,
        COOL
    } state_t;

    state_t             state_reg, state_next;
    logic               fire_q_reg;
    logic [PTR_W-1:0]   next_ptr_reg, next_ptr_next;
    logic [PTR_W-1:0]   slot_reg, slot_next;
    logic [9:0]         launch_x_reg, launch_x_next;
    logic               direction_reg, direction_next;
    logic [3:0]         timeout_reg, timeout_next;
    logic [7:0]         cool_reg, cool_next;
    logic [7:0]         shots_reg, shots_next;
    logic               drop_reg, drop_next;

    logic               fire_start;
    logic [PTR_W-1:0]   cand_idx [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] cand_free;
    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic               slot_ack;
    logic [NUM_BULLETS-1:0] start_bullet_c;
    logic               busy_c;

`ifdef BULLET_LAUNCHER_AUTOFIRE_EN
    assign fire_start = bus.fire;
`else
    assign fire_start = bus.fire & ~fire_q_reg;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_SLOT) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Candidate gi is the gi-th slot visited when scanning from next_ptr.
    generate
        for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_scan
            assign cand_idx[gi]  = PTR_W'((32'(next_ptr_reg) + 32'(gi)) % NUM_BULLETS);
            assign cand_free[gi] = ~bus.in_use[cand_idx[gi]];
        end
    endgenerate

    // Walk backwards so the earliest free candidate in scan order wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (cand_free[i]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx[i];
            end
        end
    end

    assign slot_ack = bus.in_use[slot_reg];

    always_ff @(posedge clk_60hz) begin
        if (!reset) begin
            state_reg     <= IDLE;
            fire_q_reg    <= 1'b1;
            next_ptr_reg  <= '0;
            slot_reg      <= '0;
            launch_x_reg  <= '0;
            direction_reg <= 1'b0;
            timeout_reg   <= '0;
            cool_reg      <= '0;
            shots_reg     <= '0;
            drop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fire_q_reg    <= bus.fire;
            next_ptr_reg  <= next_ptr_next;
            slot_reg      <= slot_next;
            launch_x_reg  <= launch_x_next;
            direction_reg <= direction_next;
            timeout_reg   <= timeout_next;
            cool_reg      <= cool_next;
            shots_reg     <= shots_next;
            drop_reg      <= drop_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        next_ptr_next  = next_ptr_reg;
        slot_next      = slot_reg;
        launch_x_next  = launch_x_reg;
        direction_next = direction_reg;
        timeout_next   = timeout_reg;
        cool_next      = cool_reg;
        shots_next     = shots_reg;
        drop_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fire_start) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    slot_next      = sel_idx;
                    launch_x_next  = bus.shipX;
                    direction_next = bus.direction_in;
                    state_next     = LAUNCH;
                end else begin
                    drop_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            LAUNCH: begin
                timeout_next = ACK_INIT;
                state_next   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (slot_ack) begin
                    shots_next    = shots_reg + 8'd1;
                    next_ptr_next = ptr_inc(slot_reg);
                    cool_next     = COOL_INIT;
                    state_next    = (COOLDOWN == 0) ? IDLE : COOL;
                end else begin
                    timeout_next = timeout_reg - 4'd1;
                    // Abandoned slot is skipped so a stuck slot cannot starve the pool.
                    if (timeout_reg <= 4'd1) begin
                        drop_next     = 1'b1;
                        next_ptr_next = ptr_inc(slot_reg);
                        state_next    = IDLE;
                    end
                end
            end
            COOL: begin
                cool_next = cool_reg - 8'd1;
                if (cool_reg <= 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        start_bullet_c = '0;
        busy_c         = (state_reg != IDLE);
        if (state_reg == LAUNCH) begin
            start_bullet_c[slot_reg] = 1'b1;
        end
    end

    assign bus.start_bullet = start_bullet_c;
    assign bus.busy         = busy_c;
    assign bus.direction    = direction_reg;
    assign bus.launch_x     = launch_x_reg;
    assign bus.drop         = drop_reg;
    assign bus.shots_fired  = shots_reg;

    a_start_onehot0: assert property (@(posedge clk_60hz) disable iff (!reset)
        $onehot0(start_bullet_c));
    a_start_single_cycle: assert property (@(posedge clk_60hz) disable iff (!reset)
        (start_bullet_c != '0) |=> (start_bullet_c == '0));

endmodule

// File: tb/tb_bullet_launcher.sv
// Directed bench for bullet_launcher: a cycle table for the basic launch/cooldown path,
// then hand-written sequences for drop, ack timeout, reset mid-launch and held fire.
module tb_bullet_launcher;

    logic clk_60hz = 1'b0;
    logic reset;
    always #5 clk_60hz = ~clk_60hz;

    bullet_launcher_if #(.NUM_BULLETS(4)) bus ();

    bullet_launcher #(
        .NUM_BULLETS(4),
        .COOLDOWN   (8),
        .ACK_TIMEOUT(3)
    ) dut (
        .clk_60hz(clk_60hz),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        logic       fire;
        logic       dir;
        logic [9:0] ship;
        logic [3:0] in_use;
        logic [3:0] e_start;
        logic       e_busy;
        logic       e_drop;
        logic [7:0] e_shots;
        logic [9:0] e_lx;
        logic       e_dir;
    } vec_t;

    vec_t vecs [18];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk_60hz);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " start"}, int'(bus.start_bullet), 0);
        check({tag, " busy"}, int'(bus.busy), 0);
        check({tag, " drop"}, int'(bus.drop), 0);
        check({tag, " shots"}, int'(bus.shots_fired), 0);
        check({tag, " launch_x"}, int'(bus.launch_x), 0);
        check({tag, " direction"}, int'(bus.direction), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 30) begin
            tick();
            n++;
        end
        check({tag, " idle within bound"}, int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        int exp_strobes;

        // fire dir ship in_use | start busy drop shots lx dir
        vecs[0]  = '{1'b0, 1'b0, 10'd0,   4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0, 10'd0,   1'b0};
        vecs[1]  = '{1'b1, 1'b1, 10'd100, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0, 10'd0,   1'b0};
        vecs[2]  = '{1'b1, 1'b1, 10'd100, 4'b0000, 4'b0001, 1'b1, 1'b0, 8'd0, 10'd100, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 10'd100, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'd0, 10'd100, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 10'd100, 4'b0001, 4'b0000, 1'b0, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 10'd200, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd100, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 10'd200, 4'b0001, 4'b0010, 1'b1, 1'b0, 8'd1, 10'd200, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 10'd200, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd1, 10'd200, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 10'd200, 4'b0011, 4'b0000, 1'b1, 1'b0, 8'd2, 10'd200, 1'b0};

        reset            = 1'b0;
        bus.fire         = 1'b0;
        bus.direction_in = 1'b0;
        bus.shipX        = 10'd0;
        bus.in_use       = 4'b0000;
        tick();
        tick();
        check_all_reset("reset");
        reset = 1'b1;

        // Basic launch, ack, cooldown with an ignored press, then second slot.
        for (int i = 0; i < 18; i++) begin
            bus.fire         = vecs[i].fire;
            bus.direction_in = vecs[i].dir;
            bus.shipX        = vecs[i].ship;
            bus.in_use       = vecs[i].in_use;
            tick();
            $display("[TB] vec %0d fire=%b in_use=%b start=%b busy=%b drop=%b shots=%0d lx=%0d dir=%b",
                     i, vecs[i].fire, vecs[i].in_use, bus.start_bullet, bus.busy, bus.drop,
                     bus.shots_fired, bus.launch_x, bus.direction);
            check($sformatf("vec%0d start", i), int'(bus.start_bullet), int'(vecs[i].e_start));
            check($sformatf("vec%0d busy", i), int'(bus.busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d drop", i), int'(bus.drop), int'(vecs[i].e_drop));
            check($sformatf("vec%0d shots", i), int'(bus.shots_fired), int'(vecs[i].e_shots));
            check($sformatf("vec%0d launch_x", i), int'(bus.launch_x), int'(vecs[i].e_lx));
            check($sformatf("vec%0d direction", i), int'(bus.direction), int'(vecs[i].e_dir));
        end

        // Third press lands on slot 2.
        bus.fire = 1'b0;
        wait_idle("third");
        bus.fire  = 1'b1;
        bus.shipX = 10'd300;
        tick();
        tick();
        $display("[TB] third press start=%b lx=%0d", bus.start_bullet, bus.launch_x);
        check("third start", int'(bus.start_bullet), 4'b0100);
        check("third launch_x", int'(bus.launch_x), 300);
        bus.fire = 1'b0;
        tick();
        check("third strobe one cycle", int'(bus.start_bullet), 0);
        bus.in_use = 4'b0111;
        tick();
        check("third shots", int'(bus.shots_fired), 3);

        // All slots busy: one drop pulse, no strobe, count unchanged.
        wait_idle("full");
        bus.in_use = 4'b1111;
        bus.fire   = 1'b0;
        tick();
        bus.fire = 1'b1;
        tick();
        check("full select busy", int'(bus.busy), 1);
        check("full select start", int'(bus.start_bullet), 0);
        tick();
        $display("[TB] full pool drop=%b busy=%b start=%b", bus.drop, bus.busy, bus.start_bullet);
        check("full drop", int'(bus.drop), 1);
        check("full start", int'(bus.start_bullet), 0);
        check("full busy", int'(bus.busy), 0);
        tick();
        check("full drop one cycle", int'(bus.drop), 0);
        check("full shots", int'(bus.shots_fired), 3);

        // Slot never acks: drop three cycles after WAIT_ACK entry, pointer moves to slot 1.
        reset = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        bus.in_use = 4'b0000;
        bus.fire   = 1'b0;
        tick();
        bus.fire         = 1'b1;
        bus.shipX        = 10'd321;
        bus.direction_in = 1'b1;
        tick();
        tick();
        check("timeout start", int'(bus.start_bullet), 4'b0001);
        tick();
        tick();
        check("timeout drop early1", int'(bus.drop), 0);
        tick();
        check("timeout drop early2", int'(bus.drop), 0);
        check("timeout still busy", int'(bus.busy), 1);
        tick();
        $display("[TB] ack timeout drop=%b busy=%b", bus.drop, bus.busy);
        check("timeout drop", int'(bus.drop), 1);
        check("timeout idle", int'(bus.busy), 0);
        bus.fire = 1'b0;
        tick();
        bus.fire = 1'b1;
        tick();
        tick();
        check("after timeout start", int'(bus.start_bullet), 4'b0010);
        tick();
        check("after timeout waiting", int'(bus.busy), 1);

        // Reset during WAIT_ACK with fire held through release.
        reset = 1'b0;
        tick();
        $display("[TB] mid-launch reset busy=%b lx=%0d dir=%b", bus.busy, bus.launch_x, bus.direction);
        check_all_reset("midreset");
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("held fire start %0d", i), int'(bus.start_bullet), 0);
            check($sformatf("held fire busy %0d", i), int'(bus.busy), 0);
        end
        bus.fire = 1'b0;
        tick();
        bus.fire = 1'b1;
        tick();
        tick();
        check("refire start", int'(bus.start_bullet), 4'b0001);

        // Fire held for 40 frames with acks modelled.
        reset    = 1'b0;
        bus.fire = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        bus.in_use = 4'b0000;
        tick();
        strobes  = 0;
        bus.fire = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.start_bullet != 4'b0000) begin
                strobes++;
                bus.in_use = bus.in_use | bus.start_bullet;
            end
        end
        bus.fire = 1'b0;
`ifdef BULLET_LAUNCHER_AUTOFIRE_EN
        exp_strobes = 4;
`else
        exp_strobes = 1;
`endif
        $display("[TB] held fire strobes=%0d shots=%0d", strobes, bus.shots_fired);
        check("held strobes", strobes, exp_strobes);
        check("held shots", int'(bus.shots_fired), exp_strobes);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
